// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and elaboration-time helpers for FFT twiddle generation
package fft_pkg;
    localparam real PI = 3.14159265358979323846;
    function automatic int tw_one(int w);
        return 1 << (w - 2);
    endfunction
    function automatic int cos_entry(int i, int n_log2, int w);
        real v;
        v = real'(tw_one(w)) * $cos(2.0 * PI * real'(i) / real'(1 << n_log2));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction
    function automatic int clog2(int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int clamp_stage(int s, int n_log2);
        return (s == 0 || s > n_log2) ? n_log2 : s;
    endfunction
endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: dual-read synchronous quarter-wave cosine ROM, C[i] = round(2^(W-2)*cos(2*pi*i/N)), i = 0..N/4
// ports: clk; cos_addr_i/sin_addr_i read addresses; cos_o/sin_o registered table entries
module twiddle_qrom
    import fft_pkg::*;
#(
    parameter int N_LOG2 = 10,
    parameter int W      = 18,
    parameter int AW     = N_LOG2 - 1
) (
    input  logic                 clk,
    input  logic [AW-1:0]        cos_addr_i,
    input  logic [AW-1:0]        sin_addr_i,
    output logic signed [W-1:0]  cos_o,
    output logic signed [W-1:0]  sin_o
);
    localparam int DEPTH = (1 << (N_LOG2 - 2)) + 1;
    logic signed [W-1:0] rom [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = W'(cos_entry(i, N_LOG2, W));
    end
    always_ff @(posedge clk) begin
        cos_o <= rom[cos_addr_i];
        sin_o <= rom[sin_addr_i];
    end
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: radix-2 SDF stage twiddle generator, quarter-wave table folded by symmetry, 3-cycle latency
// ports: clk; rst (sync, active-low); tw_valid_in stream valid; stage_log2 block length exponent;
//        inverse direction; tw_re/tw_im twiddle; tw_valid_out; tw_sync marks k = 0
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = 10,
    parameter int W      = 18
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tw_valid_in,
    input  logic [clog2(N_LOG2 + 1)-1:0]    stage_log2,
    input  logic                            inverse,
    output logic signed [W-1:0]             tw_re,
    output logic signed [W-1:0]             tw_im,
    output logic                            tw_valid_out,
    output logic                            tw_sync
);
    localparam int AW = N_LOG2 - 1;
    localparam int MW = clog2(N_LOG2 + 1);
    localparam logic [N_LOG2-1:0] Q = N_LOG2'(1 << (N_LOG2 - 2));
    localparam logic signed [W-1:0] ONE = W'(tw_one(W));
    logic [N_LOG2-1:0] k_q, k_d, j, jp;
    logic [N_LOG2:0] len;
    logic [MW-1:0] m_q, m_cur;
    logic [AW-1:0] ca_q, sa_q, ca_d, sa_d;
    logic inv_q, inv_cur, start, unity, fold;
    logic v1_q, sync1_q, unity1_q, fold1_q, inv1_q;
    logic v2_q, sync2_q, unity2_q, fold2_q, inv2_q;
    logic signed [W-1:0] cos_r, sin_r;
    // A block start uses the live config so the latch and the first twiddle agree.
    always_comb begin
        start   = tw_valid_in && k_q == '0;
        m_cur   = start ? MW'(clamp_stage(int'(stage_log2), N_LOG2)) : m_q;
        inv_cur = start ? inverse : inv_q;
        len     = (N_LOG2 + 1)'(1) << m_cur;
        k_d     = (!tw_valid_in || {1'b0, k_q} == len - 1'b1) ? '0 : k_q + 1'b1;
        unity   = {k_q, 1'b0} >= len;
        j       = k_q << (N_LOG2 - int'(m_cur));
        fold    = j > Q;
        jp      = j - Q;
        ca_d    = AW'(fold ? Q - jp : j);
        sa_d    = AW'(fold ? jp : Q - j);
    end
    twiddle_qrom #(.N_LOG2(N_LOG2), .W(W), .AW(AW)) u_rom (
        .clk       (clk),
        .cos_addr_i(ca_q),
        .sin_addr_i(sa_q),
        .cos_o     (cos_r),
        .sin_o     (sin_r)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q          <= '0;
            m_q          <= MW'(N_LOG2);
            inv_q        <= 1'b0;
            ca_q         <= '0;
            sa_q         <= '0;
            {v1_q, sync1_q, unity1_q, fold1_q, inv1_q} <= '0;
            {v2_q, sync2_q, unity2_q, fold2_q, inv2_q} <= '0;
            tw_re        <= '0;
            tw_im        <= '0;
            tw_valid_out <= 1'b0;
            tw_sync      <= 1'b0;
        end else begin
            k_q <= k_d;
            if (start) begin
                m_q   <= m_cur;
                inv_q <= inv_cur;
            end
            ca_q <= ca_d;
            sa_q <= sa_d;
            {v1_q, sync1_q, unity1_q, fold1_q, inv1_q} <= {tw_valid_in, start, unity, fold, inv_cur};
            {v2_q, sync2_q, unity2_q, fold2_q, inv2_q} <= {v1_q, sync1_q, unity1_q, fold1_q, inv1_q};
            tw_valid_out <= v2_q;
            tw_sync      <= sync2_q;
            if (v2_q) begin
                tw_re <= unity2_q ? ONE : (fold2_q ? -cos_r : cos_r);
                tw_im <= unity2_q ? '0 : (inv2_q ? sin_r : -sin_r);
            end
        end
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed checks of twiddle_gen at N_LOG2=4 (exact values) and N_LOG2=10 (float reference)
module tb_twiddle_gen;
    localparam real PI = 3.14159265358979323846;
    localparam int RE16[8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
    localparam int SN16[8] = '{0, 25080, 46341, 60547, 65536, 60547, 46341, 25080};
    logic clk, rst;
    logic v4, inv4, vo4, sy4;
    logic [2:0] s4;
    logic signed [17:0] re4, im4;
    logic v10, inv10, vo10, sy10;
    logic [3:0] s10;
    logic signed [17:0] re10, im10;
    int err = 0;
    int n_chk = 0;

    twiddle_gen #(.N_LOG2(4), .W(18)) dut4 (
        .clk(clk), .rst(rst), .tw_valid_in(v4), .stage_log2(s4), .inverse(inv4),
        .tw_re(re4), .tw_im(im4), .tw_valid_out(vo4), .tw_sync(sy4)
    );
    twiddle_gen #(.N_LOG2(10), .W(18)) dut10 (
        .clk(clk), .rst(rst), .tw_valid_in(v10), .stage_log2(s10), .inverse(inv10),
        .tw_re(re10), .tw_im(im10), .tw_valid_out(vo10), .tw_sync(sy10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int e_re4(int k, int m);
        return (2 * k >= (1 << m)) ? 65536 : RE16[k << (4 - m)];
    endfunction
    function automatic int e_im4(int k, int m, bit inv);
        return (2 * k >= (1 << m)) ? 0 : (inv ? SN16[k << (4 - m)] : -SN16[k << (4 - m)]);
    endfunction
    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk += 8;
        if (re4 !== 18'sd0) begin err++; $display("FAIL reset re4 got %0d want 0", re4); end
        if (im4 !== 18'sd0) begin err++; $display("FAIL reset im4 got %0d want 0", im4); end
        if (vo4 !== 1'b0) begin err++; $display("FAIL reset vo4 got %b want 0", vo4); end
        if (sy4 !== 1'b0) begin err++; $display("FAIL reset sy4 got %b want 0", sy4); end
        if (re10 !== 18'sd0) begin err++; $display("FAIL reset re10 got %0d want 0", re10); end
        if (im10 !== 18'sd0) begin err++; $display("FAIL reset im10 got %0d want 0", im10); end
        if (vo10 !== 1'b0) begin err++; $display("FAIL reset vo10 got %b want 0", vo10); end
        if (sy10 !== 1'b0) begin err++; $display("FAIL reset sy10 got %b want 0", sy10); end
        rst = 1'b1;
    endtask

    task automatic test_forward_inverse();
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 19; t++) begin
                @(negedge clk);
                if (t >= 3) begin
                    int k;
                    k = t - 3;
                    n_chk += 4;
                    if (vo4 !== 1'b1) begin err++; $display("FAIL dir%0d valid k=%0d got %b want 1", d, k, vo4); end
                    if (sy4 !== (k == 0)) begin err++; $display("FAIL dir%0d sync k=%0d got %b want %b", d, k, sy4, k == 0); end
                    if (int'(re4) !== e_re4(k, 4)) begin err++; $display("FAIL dir%0d re k=%0d got %0d want %0d", d, k, re4, e_re4(k, 4)); end
                    if (int'(im4) !== e_im4(k, 4, d[0])) begin err++; $display("FAIL dir%0d im k=%0d got %0d want %0d", d, k, im4, e_im4(k, 4, d[0])); end
                end
                v4 = (t < 16);
                s4 = 3'd4;
                inv4 = d[0];
            end
        end
    endtask

    task automatic test_stage2();
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                int k;
                k = (t - 3) % 4;
                n_chk += 4;
                if (vo4 !== 1'b1) begin err++; $display("FAIL m2 valid t=%0d got %b want 1", t, vo4); end
                if (sy4 !== (k == 0)) begin err++; $display("FAIL m2 sync t=%0d got %b want %b", t, sy4, k == 0); end
                if (int'(re4) !== e_re4(k, 2)) begin err++; $display("FAIL m2 re k=%0d got %0d want %0d", k, re4, e_re4(k, 2)); end
                if (int'(im4) !== e_im4(k, 2, 1'b0)) begin err++; $display("FAIL m2 im k=%0d got %0d want %0d", k, im4, e_im4(k, 2, 1'b0)); end
            end
            v4 = (t < 12);
            s4 = 3'd2;
            inv4 = 1'b0;
        end
    endtask

    task automatic test_gap();
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                int u, k;
                bit ve;
                u = t - 3;
                ve = (u != 6);
                k = (u < 6) ? u : u - 7;
                n_chk++;
                if (vo4 !== ve) begin err++; $display("FAIL gap valid u=%0d got %b want %b", u, vo4, ve); end
                if (ve) begin
                    n_chk += 3;
                    if (sy4 !== (k == 0)) begin err++; $display("FAIL gap sync u=%0d got %b want %b", u, sy4, k == 0); end
                    if (int'(re4) !== e_re4(k, 4)) begin err++; $display("FAIL gap re u=%0d got %0d want %0d", u, re4, e_re4(k, 4)); end
                    if (int'(im4) !== e_im4(k, 4, 1'b0)) begin err++; $display("FAIL gap im u=%0d got %0d want %0d", u, im4, e_im4(k, 4, 1'b0)); end
                end
            end
            v4 = (t < 13 && t != 6);
            s4 = 3'd4;
            inv4 = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic [2:0] cv[2];
        cv[0] = 3'd0;
        cv[1] = 3'd7;
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < 19; t++) begin
                @(negedge clk);
                if (t >= 3) begin
                    int k;
                    k = t - 3;
                    n_chk += 3;
                    if (sy4 !== (k == 0)) begin err++; $display("FAIL clamp%0d sync k=%0d got %b want %b", cv[c], k, sy4, k == 0); end
                    if (int'(re4) !== e_re4(k, 4)) begin err++; $display("FAIL clamp%0d re k=%0d got %0d want %0d", cv[c], k, re4, e_re4(k, 4)); end
                    if (int'(im4) !== e_im4(k, 4, 1'b0)) begin err++; $display("FAIL clamp%0d im k=%0d got %0d want %0d", cv[c], k, im4, e_im4(k, 4, 1'b0)); end
                end
                v4 = (t < 16);
                s4 = cv[c];
                inv4 = 1'b0;
            end
        end
    endtask

    task automatic test_cfg_change();
        for (int t = 0; t < 27; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                int u, k, m;
                bit iv;
                u = t - 3;
                m = (u < 16) ? 4 : 2;
                iv = (u >= 16);
                k = (u < 16) ? u : (u - 16) % 4;
                n_chk += 3;
                if (sy4 !== (k == 0)) begin err++; $display("FAIL cfg sync u=%0d got %b want %b", u, sy4, k == 0); end
                if (int'(re4) !== e_re4(k, m)) begin err++; $display("FAIL cfg re u=%0d got %0d want %0d", u, re4, e_re4(k, m)); end
                if (int'(im4) !== e_im4(k, m, iv)) begin err++; $display("FAIL cfg im u=%0d got %0d want %0d", u, im4, e_im4(k, m, iv)); end
            end
            v4 = (t < 24);
            s4 = (t < 3) ? 3'd4 : 3'd2;
            inv4 = (t >= 3);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t == 6) begin
                n_chk += 4;
                if (re4 !== 18'sd0) begin err++; $display("FAIL rstmid re got %0d want 0", re4); end
                if (im4 !== 18'sd0) begin err++; $display("FAIL rstmid im got %0d want 0", im4); end
                if (vo4 !== 1'b0) begin err++; $display("FAIL rstmid valid got %b want 0", vo4); end
                if (sy4 !== 1'b0) begin err++; $display("FAIL rstmid sync got %b want 0", sy4); end
            end else if (t >= 7) begin
                int u, k;
                bit ve;
                u = t - 3;
                ve = (u >= 6 && u < 10);
                k = u - 6;
                n_chk++;
                if (vo4 !== ve) begin err++; $display("FAIL rstmid valid t=%0d got %b want %b", t, vo4, ve); end
                if (ve) begin
                    n_chk += 3;
                    if (sy4 !== (k == 0)) begin err++; $display("FAIL rstmid sync t=%0d got %b want %b", t, sy4, k == 0); end
                    if (int'(re4) !== e_re4(k, 4)) begin err++; $display("FAIL rstmid re k=%0d got %0d want %0d", k, re4, e_re4(k, 4)); end
                    if (int'(im4) !== e_im4(k, 4, 1'b0)) begin err++; $display("FAIL rstmid im k=%0d got %0d want %0d", k, im4, e_im4(k, 4, 1'b0)); end
                end
            end
            rst = (t != 5);
            v4 = (t < 10);
            s4 = 3'd4;
            inv4 = 1'b0;
        end
    endtask

    task automatic test_sweep();
        bit hv[4], hi[4];
        int hk[4], hm[4];
        int m, iv, k, b;
        m = 1; iv = 0; k = 0; b = 0;
        for (int i = 0; i < 4; i++) hv[i] = 1'b0;
        for (int t = 0; t < 8184 + 3; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                int s, er, ei, dr, di;
                real a;
                bit un;
                s = (t + 1) % 4;
                n_chk++;
                if (vo10 !== hv[s]) begin err++; $display("FAIL sweep valid t=%0d got %b want %b", t, vo10, hv[s]); end
                if (hv[s]) begin
                    a = 2.0 * PI * real'(hk[s]) / real'(1 << hm[s]);
                    un = (2 * hk[s] >= (1 << hm[s]));
                    er = un ? 65536 : rnd(65536.0 * $cos(a));
                    ei = un ? 0 : rnd((hi[s] ? 65536.0 : -65536.0) * $sin(a));
                    dr = int'(re10) - er;
                    di = int'(im10) - ei;
                    n_chk += 3;
                    if (sy10 !== (hk[s] == 0)) begin err++; $display("FAIL sweep sync m=%0d k=%0d got %b want %b", hm[s], hk[s], sy10, hk[s] == 0); end
                    if (dr > 1 || dr < -1) begin err++; $display("FAIL sweep re m=%0d inv=%0d k=%0d got %0d want %0d", hm[s], hi[s], hk[s], re10, er); end
                    if (di > 1 || di < -1) begin err++; $display("FAIL sweep im m=%0d inv=%0d k=%0d got %0d want %0d", hm[s], hi[s], hk[s], im10, ei); end
                end
            end
            if (t < 8184) begin
                v10 = 1'b1;
                s10 = 4'(m);
                inv10 = iv[0];
                hv[t % 4] = 1'b1;
                hk[t % 4] = k;
                hm[t % 4] = m;
                hi[t % 4] = iv[0];
                k++;
                if (k == (1 << m)) begin
                    k = 0;
                    b++;
                    if (b == 2) begin
                        b = 0;
                        m++;
                        if (m == 11) begin
                            m = 1;
                            iv++;
                        end
                    end
                end
            end else begin
                v10 = 1'b0;
                hv[t % 4] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        v4 = 1'b0; s4 = 3'd4; inv4 = 1'b0;
        v10 = 1'b0; s10 = 4'd10; inv10 = 1'b0;
        test_reset();
        test_forward_inverse();
        test_stage2();
        test_gap();
        test_clamp();
        test_cfg_change();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", err, n_chk);
        $finish;
    end
endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Parametrised twiddle-factor generator for radix-2 SDF FFT stages. It is the successor of the fixed 16-point rotator.
- Supports any power-of-two FFT size and a run-time selectable stage length, forward or inverse direction, and configurable word width.
- Stores one quarter-wave cosine table and derives all twiddles by symmetry. Sits beside each butterfly stage and feeds the complex multiplier.

Parameters:
- N_LOG2, 10, log2 of maximum FFT size N (range 3..14).
- W, 18, output word width, signed two's complement, Q(W-2): 1.0 = 2^(W-2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- tw_valid_in  in  1  stream valid; held high for the duration of a block stream
- stage_log2  in  $clog2(N_LOG2+1)  m, stage block length L = 2^m; legal 1..N_LOG2
- inverse  in  1  0 = forward (cos − j·sin), 1 = inverse (cos + j·sin)
- tw_re  out  W  twiddle real part
- tw_im  out  W  twiddle imaginary part
- tw_valid_out  out  1  tw_re/tw_im valid
- tw_sync  out  1  one-cycle pulse accompanying the output for k = 0 of each block

Behaviour:
- Reset (rst = 0 at a clk edge):
  - k counter = 0; all pipeline registers cleared.
  - tw_re = 0, tw_im = 0, tw_valid_out = 0, tw_sync = 0.
  - Reset mid-stream discards all in-flight data; the first output after release is k = 0.
- Counter k:
  - Advances by 1 each cycle tw_valid_in = 1; wraps from L−1 to 0.
  - When tw_valid_in = 0, k is forced to 0 on the next edge, so a resumed stream always starts at k = 0.
- Config latch:
  - stage_log2 and inverse are captured into m_q/inv_q on any cycle where tw_valid_in = 1 and k = 0.
  - Changes at any other time take effect at the next block start.
  - stage_log2 = 0 or > N_LOG2 is clamped to N_LOG2.
- Twiddle law for block length L, half H = L/2:
  - k < H: twiddle index j = k·(N/L) = k << (N_LOG2 − m), with j in [0, N/2).
  - k ≥ H: unity output, re = 2^(W-2), im = 0.
- Quarter-wave fold, Q = N/4, table C[i] = round(2^(W-2)·cos(2πi/N)) for i = 0..Q:
  - j ≤ Q: cos = C[j], sin = C[Q − j].
  - j > Q: j' = j − Q, cos = −C[Q − j'], sin = C[j'].
  - tw_re = cos. tw_im = −sin (forward) or +sin (inverse).
  - Negation never overflows because |C| ≤ 2^(W-2).
- Pipeline, total latency 3 cycles from tw_valid_in sample to tw_valid_out:
  - P1 registers the two ROM addresses, fold flag, unity flag, sync flag and valid.
  - P2 is the synchronous ROM read; flags are delayed alongside.
  - P3 applies negation/select into the output registers.
- tw_valid_out is tw_valid_in delayed by 3. tw_sync is (valid && k = 0) delayed by 3.
- When tw_valid_out = 0, tw_re/tw_im hold their last value. Consumers must qualify with tw_valid_out.
- L = 2 (m = 1): k = 0 gives (2^(W-2), 0) from the table; k = 1 gives unity.
- Back-to-back blocks: no bubble. k = L−1 is followed directly by k = 0, with tw_sync re-asserted.

Decomposition:
- Shared package fft_pkg:
  - TW_ONE(W) constant (1 << (W-2)).
  - Function for the table entry cos value.
  - clog2 helper.
  - Stage-length clamp function.
- Sub-module twiddle_qrom:
  - Dual-read-port synchronous ROM, depth N/4+1, width W.
  - Contents generated at elaboration from the fft_pkg cos function; no external init file.
  - One port reads the cos address, the other reads the sin address.

Test Plan:
- N_LOG2=4, W=18, m=4, inverse=0, 16 valid cycles → outputs 3 cycles later:
  - k=0: (65536, 0)
  - k=2: (46341, −46341)
  - k=4: (0, −65536)
  - k=6: (−46341, −46341)
  - k=8..15: (65536, 0)
  - tw_sync only on k=0
- Same stream with inverse=1 → every tw_im sign flipped. k=4 gives (0, 65536); tw_re unchanged.
- N_LOG2=4, m=2 → k=0: (65536, 0); k=1: (0, −65536); k=2,3: unity. Pattern repeats every 4 cycles with tw_sync each period.
- Drop tw_valid_in for 1 cycle at k=5, then raise again → next sampled k = 0. tw_valid_out shows a 1-cycle gap exactly 3 cycles later.
- rst=0 for 1 cycle mid-block → next edge shows all outputs 0. After release with valid high, the first output appears 3 cycles later with k=0 and tw_sync=1.
- N_LOG2=10, W=18, sweep m=1..10 in both directions, plus stage_log2 changed mid-block:
  - Every valid output matches the floating-point reference rounded to within 1 LSB.
  - The config change takes effect only at the following k=0.
